mux_serializer_ctrl: RTL and testbench

//  Upstream controller for the 8:1 bit-select mux. Accepts a parallel word over a

---
 rtl/mux_serializer_ctrl.sv | 150 +++++++++++++++
 tb/tb_mux_serializer_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_serializer_ctrl.sv
// -----------------------------------------------------------------------------
// mux_serializer_ctrl
//
// Drives an external 8:1 bit-select mux. Together with that mux it forms a
// parallel-in / serial-out serializer. A word is accepted over a valid/ready
// handshake and held on the mux data inputs. The mux select is then stepped
// LSB-first (0..7). Each bit is held for HOLD_CYCLES clocks. The mux output is
// returned as a paced serial stream with first/last frame markers. A new word
// may be loaded in the final cycle of bit 7, so back-to-back frames run with
// no idle gap between them.
//
// Ports
//   clk        in   system clock, rising-edge
//   rst        in   synchronous active-high reset
//   in_data    in   [7:0] parallel word to serialize
//   in_valid   in   in_data valid
//   in_ready   out  word can be accepted this cycle
//   mux_in     out  [7:0] registered word driven to the mux data inputs
//   mux_sel    out  [2:0] registered bit index driven to the mux select
//   mux_out    in   mux output (combinational from mux_in/mux_sel)
//   bit_out    out  serial bit (mux_out gated by bit_valid)
//   bit_valid  out  bit_out carries a data bit this cycle
//   bit_first  out  first cycle of bit 0
//   bit_last   out  every hold cycle of bit 7
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no frame in progress, in_ready=1, waiting for a word
// SHIFT | frame in progress, stepping mux_sel 0..7, bit_valid=1
// -----------------------------------------------------------------------------
module mux_serializer_ctrl #(
   parameter int HOLD_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic [7:0] mux_in,
   output logic [2:0] mux_sel,
   input  logic       mux_out,
   output logic       bit_out,
   output logic       bit_valid,
   output logic       bit_first,
   output logic       bit_last
);

   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_CYCLES - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [HW-1:0] hold_cnt;
   logic          hold_tc;
   logic          eof;
   logic          load;

   // hold_cnt reaches its terminal count in the last clock of the current bit.
   assign hold_tc = (hold_cnt == HOLD_TC);
   // The final clock of bit 7 is the only SHIFT cycle that can take a new word.
   assign eof     = (state == SHIFT) && (mux_sel == 3'd7) && hold_tc;
   assign load    = in_valid && in_ready;

   // state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            if (eof && !in_valid) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // output logic; all handshake and stream outputs are forced low during reset
   always_comb begin
      in_ready  = 1'b0;
      bit_valid = 1'b0;
      if (!rst) begin
         case (state)
            IDLE: begin
               in_ready  = 1'b1;
               bit_valid = 1'b0;
            end
            SHIFT: begin
               in_ready  = eof;
               bit_valid = 1'b1;
            end
            default: begin
               in_ready  = 1'b0;
               bit_valid = 1'b0;
            end
         endcase
      end
   end

   assign bit_out   = mux_out & bit_valid;
   // The first marker covers only the first hold cycle of bit 0. The last
   // marker covers every hold cycle of bit 7.
   assign bit_first = bit_valid && (mux_sel == 3'd0) && (hold_cnt == '0);
   assign bit_last  = bit_valid && (mux_sel == 3'd7);

   // Datapath: word register, bit index and per-bit hold timer.
   always_ff @(posedge clk) begin
      if (rst) begin
         mux_in   <= 8'h00;
         mux_sel  <= 3'd0;
         hold_cnt <= '0;
      end else if (load) begin
         mux_in   <= in_data;
         mux_sel  <= 3'd0;
         hold_cnt <= '0;
      end else if (state == SHIFT) begin
         if (hold_tc) begin
            hold_cnt <= '0;
            // The wrap 7->0 happens only at end of frame when the frame
            // returns to IDLE; the index never free-runs otherwise.
            if (eof) begin
               mux_sel <= 3'd0;
            end else begin
               mux_sel <= mux_sel + 3'd1;
            end
         end else begin
            hold_cnt <= hold_cnt + HW'(1);
         end
      end
   end

endmodule

// File: tb/tb_mux_serializer_ctrl.sv
module tb_mux_serializer_ctrl;

   typedef struct {
      logic       b;
      logic       f;
      logic       l;
      logic [2:0] s;
      logic [7:0] w;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_s [2];
   logic [7:0] idat  [2];
   logic       ivld  [2];
   logic       rdy   [2];
   logic [7:0] min   [2];
   logic [2:0] msel  [2];
   logic       mo    [2];
   logic       bo    [2];
   logic       bv    [2];
   logic       bf    [2];
   logic       bl    [2];

   int   hold [2] = '{1, 3};
   exp_t q [2][$];

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   // behavioural 8:1 mux
   assign mo[0] = min[0][msel[0]];
   assign mo[1] = min[1][msel[1]];

   mux_serializer_ctrl #(.HOLD_CYCLES(1)) u_dut1 (
      .clk(clk), .rst(rst_s[0]), .in_data(idat[0]), .in_valid(ivld[0]),
      .in_ready(rdy[0]), .mux_in(min[0]), .mux_sel(msel[0]), .mux_out(mo[0]),
      .bit_out(bo[0]), .bit_valid(bv[0]), .bit_first(bf[0]), .bit_last(bl[0])
   );

   mux_serializer_ctrl #(.HOLD_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst_s[1]), .in_data(idat[1]), .in_valid(ivld[1]),
      .in_ready(rdy[1]), .mux_in(min[1]), .mux_sel(msel[1]), .mux_out(mo[1]),
      .bit_out(bo[1]), .bit_valid(bv[1]), .bit_first(bf[1]), .bit_last(bl[1])
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Scoreboard step for one DUT, run on every falling edge.
   task automatic monitor(input int d);
      exp_t e;
      logic er;
      if (rst_s[d]) begin
         chk($sformatf("d%0d rst in_ready", d), rdy[d], 0);
         chk($sformatf("d%0d rst bit_valid", d), bv[d], 0);
         chk($sformatf("d%0d rst bit_out", d), bo[d], 0);
         chk($sformatf("d%0d rst bit_first", d), bf[d], 0);
         chk($sformatf("d%0d rst bit_last", d), bl[d], 0);
         q[d].delete();
      end else begin
         // ready in IDLE (no pending bits) or in the last bit cycle of a frame
         er = (q[d].size() <= 1);
         chk($sformatf("d%0d in_ready", d), rdy[d], er);
         if (q[d].size() > 0) begin
            e = q[d].pop_front();
            chk($sformatf("d%0d bit_valid", d), bv[d], 1);
            chk($sformatf("d%0d bit_out", d), bo[d], e.b);
            chk($sformatf("d%0d bit_first", d), bf[d], e.f);
            chk($sformatf("d%0d bit_last", d), bl[d], e.l);
            chk($sformatf("d%0d mux_sel", d), msel[d], e.s);
            chk($sformatf("d%0d mux_in", d), min[d], e.w);
         end else begin
            chk($sformatf("d%0d idle bit_valid", d), bv[d], 0);
            chk($sformatf("d%0d idle bit_out", d), bo[d], 0);
            chk($sformatf("d%0d idle bit_first", d), bf[d], 0);
            chk($sformatf("d%0d idle bit_last", d), bl[d], 0);
         end
         if (er && ivld[d]) begin
            for (int j = 0; j < 8 * hold[d]; j++) begin
               e.b = idat[d][j / hold[d]];
               e.f = (j == 0);
               e.l = ((j / hold[d]) == 7);
               e.s = 3'(j / hold[d]);
               e.w = idat[d];
               q[d].push_back(e);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      monitor(0);
      monitor(1);
   end

   task automatic send(input int d, input logic [7:0] w);
      int k;
      k = 0;
      ivld[d] = 1'b1;
      idat[d] = w;
      while (k < 200) begin
         @(negedge clk);
         if (rdy[d]) break;
         k++;
      end
      if (k >= 200) chk($sformatf("d%0d send timeout", d), 0, 1);
      @(posedge clk);
      #1;
      ivld[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int k;
      k = 0;
      while ((q[d].size() != 0 || bv[d]) && k < 500) begin
         @(posedge clk);
         #1;
         k++;
      end
      if (k >= 500) chk($sformatf("d%0d idle timeout", d), 0, 1);
      chk($sformatf("d%0d idle in_ready", d), rdy[d], 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst_s[d] = 1'b1;
         ivld[d]  = 1'b0;
         idat[d]  = 8'h00;
      end

      // reset held 3 clocks with in_valid asserted: nothing may be accepted
      ivld[0] = 1'b1;
      idat[0] = 8'hA5;
      ivld[1] = 1'b1;
      idat[1] = 8'h5A;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("d%0d reset mux_sel", d), msel[d], 0);
         chk($sformatf("d%0d reset mux_in", d), min[d], 0);
         rst_s[d] = 1'b0;
         ivld[d]  = 1'b0;
      end
      @(negedge clk);
      chk("d0 ready after reset", rdy[0], 1);
      chk("d1 ready after reset", rdy[1], 1);
      @(posedge clk);
      #1;

      // single word
      send(0, 8'hA5);
      wait_idle(0);

      // back-to-back words with in_valid held across the boundary
      send(0, 8'hFF);
      send(0, 8'h00);
      wait_idle(0);

      // three-cycle hold
      send(1, 8'h81);
      wait_idle(1);

      // reset in the middle of a frame, then a clean frame afterwards
      send(0, 8'h3C);
      repeat (4) @(posedge clk);
      #1;
      rst_s[0] = 1'b1;
      @(posedge clk);
      #1;
      chk("d0 midrst mux_sel", msel[0], 0);
      chk("d0 midrst mux_in", min[0], 0);
      rst_s[0] = 1'b0;
      send(0, 8'h01);
      wait_idle(0);

      // in_valid pulse mid-frame must be ignored
      send(0, 8'h5A);
      repeat (3) @(posedge clk);
      #1;
      ivld[0] = 1'b1;
      idat[0] = 8'h77;
      @(posedge clk);
      #1;
      ivld[0] = 1'b0;
      wait_idle(0);

      // random words with random gaps on both instances
      for (int i = 0; i < 6; i++) begin
         send(0, 8'($urandom_range(0, 255)));
         send(1, 8'($urandom_range(0, 255)));
         repeat ($urandom_range(0, 10)) @(posedge clk);
         #1;
      end
      wait_idle(0);
      wait_idle(1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
